// File: rtl/disp_hex_mux_n_if.sv
// Display bus between a data source and the multiplexed 7-segment driver.
// The source drives digit data and controls; the driver returns the pin-level scan outputs.
interface disp_hex_mux_n_if #(
  parameter int N_DIG = 4
);
  logic [4*N_DIG-1:0] hex;
  logic [N_DIG-1:0]   dp_in;
  logic               blank_lz;
  logic [N_DIG-1:0]   blink_en;
  logic [N_DIG-1:0]   an;
  logic [7:0]         sseg;
  logic               frame_tick;

  modport master (
    output hex, dp_in, blank_lz, blink_en,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  hex, dp_in, blank_lz, blink_en,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/disp_hex_mux_n.sv
// N-digit multiplexed hex display driver with frame-synchronous input capture,
// leading-zero blanking, per-digit blink and a frame-complete strobe.
module disp_hex_mux_n #(
  parameter int N_DIG      = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_BITS = 25
) (
  input  logic            clk,
  input  logic            reset,
  disp_hex_mux_n_if.slave bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIG);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [BLINK_BITS-1:0] blink_p0;
  logic                  load_pending;
  logic [4*N_DIG-1:0]    hex_sh;
  logic [N_DIG-1:0]      dp_sh;
  logic                  blz_sh;
  logic [N_DIG-1:0]      blk_sh;

  logic [N_DIG-1:0]      an_p1;
  logic [7:0]            sseg_p1;
  logic                  ft_p1;

  logic                  step;
  logic                  last_idx;
  logic                  capture;
  logic                  dark;
  logic                  zero_run;
  logic [N_DIG-1:0]      blank_vec;
  logic [3:0]            nib;
  logic [N_DIG-1:0]      an_nxt;
  logic [7:0]            sseg_nxt;

  assign step     = (cnt_p0 == CNT_W'(SCAN_DIV - 1));
  assign last_idx = (idx_p0 == IDX_W'(N_DIG - 1));
  // Capture only at frame boundaries so a frame is never a mix of old and new data.
  assign capture  = load_pending | (step & last_idx);

  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    // A digit is a leading zero only if it and every more-significant digit are zero.
    for (int i = N_DIG - 1; i >= 0; i--) begin
      zero_run     = zero_run & (hex_sh[4*i +: 4] == 4'h0);
      blank_vec[i] = zero_run & blz_sh & (i != 0);
    end
    nib      = hex_sh[{idx_p0, 2'b00} +: 4];
    dark     = blk_sh[idx_p0] & blink_p0[BLINK_BITS-1];
    an_nxt   = '1;
    sseg_nxt = 8'hFF;
    if (!dark) begin
      an_nxt   = ~(N_DIG'(1) << idx_p0);
      sseg_nxt = {dp_sh[idx_p0], blank_vec[idx_p0] ? 7'h7F : hex_to_seg(nib)};
    end
  end

  // Stage p0: scan/blink counters and shadow capture; stage p1: registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0       <= '0;
      idx_p0       <= '0;
      blink_p0     <= '0;
      load_pending <= 1'b1;
      hex_sh       <= '0;
      dp_sh        <= '0;
      blz_sh       <= 1'b0;
      blk_sh       <= '0;
      an_p1        <= '1;
      sseg_p1      <= 8'hFF;
      ft_p1        <= 1'b0;
    end else begin
      blink_p0 <= blink_p0 + BLINK_BITS'(1);
      if (step) begin
        cnt_p0 <= '0;
        idx_p0 <= last_idx ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (capture) begin
        hex_sh       <= bus.hex;
        dp_sh        <= bus.dp_in;
        blz_sh       <= bus.blank_lz;
        blk_sh       <= bus.blink_en;
        load_pending <= 1'b0;
      end
      ft_p1   <= step & last_idx;
      an_p1   <= an_nxt;
      sseg_p1 <= sseg_nxt;
    end
  end

  assign bus.an         = an_p1;
  assign bus.sseg       = sseg_p1;
  assign bus.frame_tick = ft_p1;
endmodule
